// File: rtl/data_pipe_m2s_pkg.sv
// Shared types and defaults for the NUM-to-1 round-robin stream interconnect.
package data_pipe_m2s_pkg;

  // Arbiter state; ARB_LOCK is only reachable when M2S_PKT_LOCK_EN is defined
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int DSIZE_DEF = 8;
  localparam int NUM_DEF   = 8;
  localparam int DEPTH_DEF = 4;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/m2s_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NUM
// for the first requester, or grants only lk_ch while a packet lock is held.
module m2s_rr_arbiter #(
  parameter int NUM   = 8,
  parameter int NSIZE = 3
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  input  logic             lock,
  input  logic [NSIZE-1:0] lk_ch,
  output logic [NSIZE-1:0] grant,
  output logic             grant_vld
);

  // Pick the locked channel or the first requester after the last winner
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (lock) begin
      grant     = lk_ch;
      grant_vld = req[lk_ch];
    end else begin
      for (int i = 1; i <= NUM; i++) begin
        if (!grant_vld && req[(int'(ptr) + i) % NUM]) begin
          grant_vld = 1'b1;
          grant     = NSIZE'((int'(ptr) + i) % NUM);
        end
      end
    end
  end

endmodule

// File: rtl/data_pipe_interconnect_m2s_rr.sv
// NUM-slave to single-master stream interconnect with round-robin arbitration
// and a DEPTH-entry registered output FIFO of {src, last, data}.
// Optional feature macro: M2S_PKT_LOCK_EN (packet-lock arbitration; when
// undefined, arbitration happens per beat and s_last is carried as data only).
module data_pipe_interconnect_m2s_rr
  import data_pipe_m2s_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NUM   = NUM_DEF,
  parameter int NSIZE = clog2_min1(NUM),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic [NUM-1:0]           s_valid,
  input  logic [NUM*DSIZE-1:0]     s_data,
  input  logic [NUM-1:0]           s_last,
  output logic [NUM-1:0]           s_ready,
  output logic                     m_valid,
  output logic [DSIZE-1:0]         m_data,
  output logic                     m_last,
  output logic [NSIZE-1:0]         m_src,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = NSIZE + 1 + DSIZE;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [NSIZE-1:0] r_ptr;

  logic [NSIZE-1:0] w_grant;
  logic             w_grant_vld;
  logic             w_lock;
  logic [NSIZE-1:0] w_lk_ch;
  logic             w_full;
  logic             w_empty;
  logic             w_act;
  logic             w_push;
  logic             w_pop;
  logic             w_wlast;
  logic [EW-1:0]    w_wdata;

`ifdef M2S_PKT_LOCK_EN
  arb_state_t       r_state;
  logic [NSIZE-1:0] r_lk_ch;

  assign w_lock  = (r_state == ARB_LOCK);
  assign w_lk_ch = r_lk_ch;
`else
  assign w_lock  = 1'b0;
  assign w_lk_ch = '0;
`endif

  m2s_rr_arbiter #(
    .NUM   (NUM),
    .NSIZE (NSIZE)
  ) u_arb (
    .req       (s_valid),
    .ptr       (r_ptr),
    .lock      (w_lock),
    .lk_ch     (w_lk_ch),
    .grant     (w_grant),
    .grant_vld (w_grant_vld)
  );

  // Full uses registered pointers only, so a same-cycle pop never opens a push
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_empty = (r_wr == r_rd);
  // No handshake is offered while frozen or while reset is being applied
  assign w_act   = clk_en & rst_n;

  // One-hot ready toward the granted slave
  always_comb begin
    s_ready = '0;
    for (int k = 0; k < NUM; k++) begin
      s_ready[k] = (w_grant == NSIZE'(k)) && w_grant_vld && !w_full && w_act;
    end
  end

  assign w_push   = |(s_valid & s_ready);
  assign m_valid  = !w_empty && w_act;
  assign w_pop    = m_valid && m_ready;
  assign w_wlast  = s_last[w_grant];
  assign w_wdata  = {w_grant, w_wlast, s_data[w_grant*DSIZE +: DSIZE]};
  assign {m_src, m_last, m_data} = r_mem[r_rd[AW-1:0]];
  assign fifo_cnt = r_wr - r_rd;

  // FIFO storage and pointers; reset clears entries so the head reads zero
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clk_en) begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= w_wdata;
        r_wr                <= r_wr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + (AW+1)'(1);
      end
    end
  end

`ifdef M2S_PKT_LOCK_EN
  // Arbitration FSM: hold the winner until its s_last beat, then advance ptr
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_ptr   <= NSIZE'(NUM - 1);
      r_state <= ARB_IDLE;
      r_lk_ch <= '0;
    end else if (w_push) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_wlast) begin
            r_ptr <= w_grant;
          end else begin
            r_state <= ARB_LOCK;
            r_lk_ch <= w_grant;
          end
        end
        ARB_LOCK: begin
          if (w_wlast) begin
            r_state <= ARB_IDLE;
            r_ptr   <= r_lk_ch;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
`else
  // Beat-level arbitration: every accepted beat moves priority past its source
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_ptr <= NSIZE'(NUM - 1);
    end else if (w_push) begin
      r_ptr <= w_grant;
    end
  end
`endif

endmodule
